// File: rtl/vga_pkg.sv
// Shared VGA display defaults, axis direction encoding and the per-axis
// step/clamp/flip rule used by the ball motion block.
package vga_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int V_DISPLAY_DEF = 480;

  typedef enum logic {
    DIR_POS = 1'b0,
    DIR_NEG = 1'b1
  } dir_e;

  typedef struct packed {
    logic [9:0] pos;
    dir_e       dir;
    logic       hit;
  } axis_t;

  // One frame of movement on a single axis; lands exactly on the limit and reverses.
  function automatic axis_t axis_step(input logic [9:0]  pos,
                                      input dir_e        dir,
                                      input logic [2:0]  speed,
                                      input logic [10:0] lo,
                                      input logic [10:0] hi);
    axis_t       r;
    logic [10:0] p11;
    logic [10:0] s11;
    r.pos = pos;
    r.dir = dir;
    r.hit = 1'b0;
    p11   = {1'b0, pos};
    s11   = {8'd0, speed};
    if (speed != 3'd0) begin
      if (dir == DIR_POS) begin
        if (p11 + s11 >= hi) begin
          r.pos = hi[9:0];
          r.dir = DIR_NEG;
          r.hit = 1'b1;
        end else begin
          r.pos = pos + {7'd0, speed};
        end
      end else begin
        if (p11 <= lo + s11) begin
          r.pos = lo[9:0];
          r.dir = DIR_POS;
          r.hit = 1'b1;
        end else begin
          r.pos = pos - {7'd0, speed};
        end
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/ball_motion_if.sv
// Frame/button inputs and ball position outputs of the ball motion block.
interface ball_motion_if;
  logic       vsync;
  logic       btn_pause;
  logic [2:0] speed;
  logic [9:0] cx;
  logic [9:0] cy;
  logic       frame_tick;
  logic [1:0] bounce;
  logic       paused;

  modport master (output vsync, btn_pause, speed,
                  input  cx, cy, frame_tick, bounce, paused);
  modport slave  (input  vsync, btn_pause, speed,
                  output cx, cy, frame_tick, bounce, paused);
endinterface

// File: rtl/btn_debounce.sv
// Two-flop synchronizer followed by a consecutive-cycle debouncer for a raw pushbutton.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1048576
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic dout
);
  localparam int            CW       = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic          level_q;

  // Any cycle where the synchronized input agrees with the level restarts the count.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q  <= 2'b00;
      cnt_q   <= '0;
      level_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], din};
      if (sync_q[1] != level_q) begin
        if (cnt_q == CNT_LAST) begin
          level_q <= sync_q[1];
          cnt_q   <= '0;
        end else begin
          cnt_q <= cnt_q + CNT_ONE;
        end
      end else begin
        cnt_q <= '0;
      end
    end
  end

  assign dout = level_q;
endmodule

// File: rtl/ball_motion.sv
// Bouncing ball position: one step per frame on each axis, pausable by a debounced button.
module ball_motion
  import vga_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int RADIUS          = 16,
  parameter int DEBOUNCE_CYCLES = 1048576
) (
  input logic          clk,
  input logic          reset,
  ball_motion_if.slave bus
);
  localparam logic [10:0] XMIN = 11'(RADIUS);
  localparam logic [10:0] XMAX = 11'(H_DISPLAY - 1 - RADIUS);
  localparam logic [10:0] YMIN = 11'(RADIUS);
  localparam logic [10:0] YMAX = 11'(V_DISPLAY - 1 - RADIUS);
  localparam logic [9:0]  X_RST = 10'(H_DISPLAY / 2);
  localparam logic [9:0]  Y_RST = 10'(V_DISPLAY / 2);

  logic       vs_q;
  logic       tick_q;
  logic       btn_db;
  logic       btn_db_q;
  logic       paused_q;
  logic [9:0] cx_q;
  logic [9:0] cy_q;
  dir_e       dx_q;
  dir_e       dy_q;
  logic [1:0] bounce_q;
  axis_t      x_d;
  axis_t      y_d;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_debounce (
    .clk   (clk),
    .reset (reset),
    .din   (bus.btn_pause),
    .dout  (btn_db)
  );

  always_comb begin
    x_d = axis_step(cx_q, dx_q, bus.speed, XMIN, XMAX);
    y_d = axis_step(cy_q, dy_q, bus.speed, YMIN, YMAX);
  end

  // paused_q seen here is the pre-edge value, so a coincident toggle affects the next frame.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vs_q     <= 1'b0;
      tick_q   <= 1'b0;
      btn_db_q <= 1'b0;
      paused_q <= 1'b0;
      cx_q     <= X_RST;
      cy_q     <= Y_RST;
      dx_q     <= DIR_POS;
      dy_q     <= DIR_POS;
      bounce_q <= 2'b00;
    end else begin
      vs_q     <= bus.vsync;
      tick_q   <= bus.vsync & ~vs_q;
      btn_db_q <= btn_db;
      if (btn_db && !btn_db_q) begin
        paused_q <= ~paused_q;
      end
      bounce_q <= 2'b00;
      if (tick_q && !paused_q) begin
        cx_q     <= x_d.pos;
        dx_q     <= x_d.dir;
        cy_q     <= y_d.pos;
        dy_q     <= y_d.dir;
        bounce_q <= {y_d.hit, x_d.hit};
      end
    end
  end

  assign bus.cx         = cx_q;
  assign bus.cy         = cy_q;
  assign bus.frame_tick = tick_q;
  assign bus.bounce     = bounce_q;
  assign bus.paused     = paused_q;
endmodule

// File: tb/tb_ball_motion.sv
// Self-checking bench for ball_motion: frame stepping, wall bounces, pause button and reset.
module tb_ball_motion;
  import vga_pkg::*;

  logic clk = 1'b0;
  logic reset;

  ball_motion_if bus1();
  ball_motion_if bus2();

  ball_motion #(.RADIUS(16), .DEBOUNCE_CYCLES(16)) dut (
    .clk(clk), .reset(reset), .bus(bus1)
  );
  ball_motion #(.H_DISPLAY(480), .V_DISPLAY(480), .RADIUS(16), .DEBOUNCE_CYCLES(16)) dut_sq (
    .clk(clk), .reset(reset), .bus(bus2)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // reference model of the 640x480 instance
  int         mx, my, mdx, mdy;
  bit         mpaused;
  logic [1:0] mb;

  logic       ft_obs, ft_after;
  logic [1:0] b_obs, b_next;
  logic [9:0] x_obs, y_obs;

  task automatic axis_ref(inout int p, inout int d, input int s, input int lo, input int hi,
                          output bit hit);
    hit = 1'b0;
    if (s == 0) return;
    p = p + d * s;
    if (d > 0 && p >= hi) begin
      p = hi; d = -1; hit = 1'b1;
    end else if (d < 0 && p <= lo) begin
      p = lo; d = 1; hit = 1'b1;
    end
  endtask

  task automatic model_step(input int s);
    bit hx, hy;
    mb = 2'b00;
    if (mpaused) return;
    axis_ref(mx, mdx, s, 16, 623, hx);
    axis_ref(my, mdy, s, 16, 463, hy);
    mb = {hy, hx};
  endtask

  task automatic model_reset();
    mx = 320; my = 240; mdx = 1; mdy = 1; mpaused = 1'b0; mb = 2'b00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    bus1.vsync = 1'b0; bus1.btn_pause = 1'b0;
    bus2.vsync = 1'b0; bus2.btn_pause = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  // one vsync pulse; samples tick, then position/bounce after the update, then bounce again
  task automatic frame(input bit sq);
    @(negedge clk);
    if (sq) bus2.vsync = 1'b1; else bus1.vsync = 1'b1;
    @(negedge clk);
    ft_obs = sq ? bus2.frame_tick : bus1.frame_tick;
    bus1.vsync = 1'b0; bus2.vsync = 1'b0;
    @(negedge clk);
    x_obs    = sq ? bus2.cx : bus1.cx;
    y_obs    = sq ? bus2.cy : bus1.cy;
    b_obs    = sq ? bus2.bounce : bus1.bounce;
    ft_after = sq ? bus2.frame_tick : bus1.frame_tick;
    @(negedge clk);
    b_next = sq ? bus2.bounce : bus1.bounce;
  endtask

  task automatic press(input int cycles);
    @(negedge clk);
    bus1.btn_pause = 1'b1;
    repeat (cycles) @(negedge clk);
    bus1.btn_pause = 1'b0;
    repeat (25) @(negedge clk);
  endtask

  task automatic test_reset();
    int ticks;
    reset = 1'b1;
    bus1.vsync = 1'b0; bus1.btn_pause = 1'b0; bus1.speed = 3'd0;
    bus2.vsync = 1'b0; bus2.btn_pause = 1'b0; bus2.speed = 3'd0;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({bus1.cx, bus1.cy, bus1.bounce, bus1.paused, bus1.frame_tick} !==
        {10'd320, 10'd240, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_values: cx=%0d cy=%0d bounce=%b paused=%b tick=%b expected 320 240 00 0 0",
               bus1.cx, bus1.cy, bus1.bounce, bus1.paused, bus1.frame_tick);
    end
    reset = 1'b0;
    model_reset();
    ticks = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus1.frame_tick === 1'b1) ticks++;
    end
    n_checks++;
    if (ticks !== 0) begin
      n_fail++;
      $display("FAIL no_tick_without_vsync: ticks=%0d expected 0", ticks);
    end
    frame(1'b0);
    n_checks++;
    if ({ft_obs, ft_after, x_obs, y_obs, b_obs} !== {1'b1, 1'b0, 10'd320, 10'd240, 2'b00}) begin
      n_fail++;
      $display("FAIL first_tick_speed0: tick=%b after=%b cx=%0d cy=%0d b=%b expected 1 0 320 240 00",
               ft_obs, ft_after, x_obs, y_obs, b_obs);
    end
  endtask

  task automatic test_speed4();
    int bounces = 0;
    do_reset();
    bus1.speed = 3'd4;
    for (int f = 1; f <= 10; f++) begin
      model_step(4);
      frame(1'b0);
      if (b_obs !== 2'b00) bounces++;
      n_checks++;
      if (x_obs !== 10'(mx) || y_obs !== 10'(my) || ft_obs !== 1'b1) begin
        n_fail++;
        $display("FAIL speed4_frame%0d: cx=%0d cy=%0d tick=%b expected %0d %0d 1", f, x_obs, y_obs, ft_obs, mx, my);
      end
    end
    n_checks++;
    if (x_obs !== 10'd360 || y_obs !== 10'd280 || bounces !== 0) begin
      n_fail++;
      $display("FAIL speed4_final: cx=%0d cy=%0d bounces=%0d expected 360 280 0", x_obs, y_obs, bounces);
    end
  endtask

  task automatic test_speed7();
    do_reset();
    bus1.speed = 3'd7;
    for (int f = 1; f <= 45; f++) begin
      model_step(7);
      frame(1'b0);
      n_checks++;
      if (x_obs !== 10'(mx) || y_obs !== 10'(my) || b_obs !== mb || b_next !== 2'b00) begin
        n_fail++;
        $display("FAIL speed7_frame%0d: cx=%0d cy=%0d b=%b bnext=%b expected %0d %0d %b 00",
                 f, x_obs, y_obs, b_obs, b_next, mx, my, mb);
      end
      if (f == 32) begin
        n_checks++;
        if (y_obs !== 10'd463 || b_obs !== 2'b10) begin
          n_fail++; $display("FAIL y_wall: cy=%0d b=%b expected 463 10", y_obs, b_obs);
        end
      end
      if (f == 33) begin
        n_checks++;
        if (y_obs !== 10'd456) begin
          n_fail++; $display("FAIL y_return: cy=%0d expected 456", y_obs);
        end
      end
      if (f == 43) begin
        n_checks++;
        if (x_obs !== 10'd621) begin
          n_fail++; $display("FAIL x_near: cx=%0d expected 621", x_obs);
        end
      end
      if (f == 44) begin
        n_checks++;
        if (x_obs !== 10'd623 || b_obs !== 2'b01) begin
          n_fail++; $display("FAIL x_wall: cx=%0d b=%b expected 623 01", x_obs, b_obs);
        end
      end
      if (f == 45) begin
        n_checks++;
        if (x_obs !== 10'd616) begin
          n_fail++; $display("FAIL x_return: cx=%0d expected 616", x_obs);
        end
      end
    end
  endtask

  task automatic test_pause();
    logic [9:0] fx, fy;
    bus1.speed = 3'd3;
    press(18);
    mpaused = 1'b1;
    n_checks++;
    if (bus1.paused !== 1'b1) begin
      n_fail++; $display("FAIL pause_on: paused=%b expected 1", bus1.paused);
    end
    fx = bus1.cx; fy = bus1.cy;
    for (int f = 0; f < 5; f++) begin
      model_step(3);
      frame(1'b0);
      n_checks++;
      if (ft_obs !== 1'b1 || x_obs !== fx || y_obs !== fy || b_obs !== 2'b00 ||
          x_obs !== 10'(mx) || y_obs !== 10'(my)) begin
        n_fail++;
        $display("FAIL paused_frame%0d: tick=%b cx=%0d cy=%0d b=%b expected 1 %0d %0d 00",
                 f, ft_obs, x_obs, y_obs, b_obs, fx, fy);
      end
    end
    for (int g = 0; g < 3; g++) press(10);
    n_checks++;
    if (bus1.paused !== 1'b1) begin
      n_fail++; $display("FAIL glitch_ignored: paused=%b expected 1", bus1.paused);
    end
    press(18);
    mpaused = 1'b0;
    n_checks++;
    if (bus1.paused !== 1'b0) begin
      n_fail++; $display("FAIL pause_off: paused=%b expected 0", bus1.paused);
    end
    for (int f = 0; f < 5; f++) begin
      model_step(3);
      frame(1'b0);
      n_checks++;
      if (x_obs !== 10'(mx) || y_obs !== 10'(my) || b_obs !== mb) begin
        n_fail++;
        $display("FAIL resume_frame%0d: cx=%0d cy=%0d b=%b expected %0d %0d %b", f, x_obs, y_obs, b_obs, mx, my, mb);
      end
    end
  endtask

  task automatic test_random();
    int s;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      s = $urandom_range(0, 7);
      bus1.speed = 3'(s);
      if ($urandom_range(0, 9) == 0) begin
        press(18);
        mpaused = ~mpaused;
        n_checks++;
        if (bus1.paused !== mpaused) begin
          n_fail++; $display("FAIL random_pause%0d: paused=%b expected %b", i, bus1.paused, mpaused);
        end
      end
      model_step(s);
      frame(1'b0);
      n_checks++;
      if (x_obs !== 10'(mx) || y_obs !== 10'(my) || b_obs !== mb || b_next !== 2'b00) begin
        n_fail++;
        $display("FAIL random_frame%0d: cx=%0d cy=%0d b=%b bnext=%b expected %0d %0d %b 00",
                 i, x_obs, y_obs, b_obs, b_next, mx, my, mb);
      end
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end
  endtask

  task automatic test_square();
    int first = 0;
    logic [9:0] hx, hy;
    logic [1:0] hb, hn;
    do_reset();
    bus2.speed = 3'd7;
    for (int f = 1; f <= 40; f++) begin
      frame(1'b1);
      if (first == 0 && b_obs !== 2'b00) begin
        first = f; hx = x_obs; hy = y_obs; hb = b_obs; hn = b_next;
      end
    end
    bus2.speed = 3'd0;
    n_checks++;
    if (first !== 32 || hb !== 2'b11 || hn !== 2'b00 || hx !== 10'd463 || hy !== 10'd463) begin
      n_fail++;
      $display("FAIL corner_hit: frame=%0d b=%b bnext=%b cx=%0d cy=%0d expected 32 11 00 463 463",
               first, hb, hn, hx, hy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus1.speed = 3'd5;
    for (int f = 0; f < 20; f++) begin
      model_step(5);
      frame(1'b0);
    end
    n_checks++;
    if (bus1.cx !== 10'(mx) || bus1.cy !== 10'(my)) begin
      n_fail++; $display("FAIL pre_reset_pos: cx=%0d cy=%0d expected %0d %0d", bus1.cx, bus1.cy, mx, my);
    end
    bus1.btn_pause = 1'b1;
    repeat (10) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_checks++;
    if ({bus1.cx, bus1.cy, bus1.bounce, bus1.paused, bus1.frame_tick} !==
        {10'd320, 10'd240, 2'b00, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL async_reset: cx=%0d cy=%0d bounce=%b paused=%b tick=%b expected 320 240 00 0 0",
               bus1.cx, bus1.cy, bus1.bounce, bus1.paused, bus1.frame_tick);
    end
    bus1.btn_pause = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    repeat (40) @(negedge clk);
    n_checks++;
    if (bus1.paused !== 1'b0 || bus1.cx !== 10'd320) begin
      n_fail++; $display("FAIL press_discarded: paused=%b cx=%0d expected 0 320", bus1.paused, bus1.cx);
    end
    model_step(5);
    frame(1'b0);
    n_checks++;
    if (x_obs !== 10'(mx) || y_obs !== 10'(my)) begin
      n_fail++; $display("FAIL post_reset_move: cx=%0d cy=%0d expected %0d %0d", x_obs, y_obs, mx, my);
    end
  endtask

  initial begin
    test_reset();
    test_speed4();
    test_speed7();
    test_pause();
    test_random();
    test_square();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
